// File: rtl/vpd_pkg.sv
// Shared types and constants for the VPD capability controller.
package vpd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    WR_REQ
  } vpd_state_e;

  localparam int          VPD_F_BIT    = 31;
  localparam logic [31:0] VPD_ERR_DATA = 32'hFFFF_FFFF;
  localparam int          VPD_ADDR_LSB = 16;

endpackage

// File: rtl/vpd_timeout_timer.sv
// Cycle counter bounding how long a storage request may stay outstanding.
module vpd_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Expiry lands on the TIMEOUT_CYCLES-th un-acked request cycle
  assign expired = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vpd_capability_ctrl.sv
// VPD Address/Data capability registers with F-flag completion, fronting a
// req/ack backing store with read-only region and timeout protection.
module vpd_capability_ctrl
  import vpd_pkg::*;
#(
  parameter int ADDR_W         = 15,
  parameter int RO_LIMIT       = 'h80,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_addr_we,
  input  logic              cfg_data_we,
  input  logic [31:0]       cfg_wdata,
  input  logic [3:0]        cfg_be,
  output logic [15:0]       vpd_addr_rd,
  output logic [31:0]       vpd_data_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  output logic              busy,
  output logic              err_ro,
  output logic              err_timeout
);

  vpd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              f_q, f_d;
  logic [31:0]       data_q, data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_ro_q, err_ro_d;
  logic              err_to_q, err_to_d;

  logic              idle, data_acc, addr_acc, is_ro;
  logic [ADDR_W-1:0] new_addr;
  logic              tmr_start, tmr_run, tmr_exp;
  logic [14:0]       addr_ext;

  assign idle     = (state_q == IDLE);
  assign data_acc = cfg_data_we && (cfg_be == 4'b1111) && idle;
  assign addr_acc = cfg_addr_we && (cfg_be[3:2] == 2'b11) && idle;
  assign new_addr = {cfg_wdata[VPD_ADDR_LSB+ADDR_W-1:VPD_ADDR_LSB+2], 2'b00};
  assign is_ro    = 32'(new_addr) < 32'(RO_LIMIT);

  assign tmr_start = addr_acc && !(cfg_wdata[VPD_F_BIT] && is_ro);
  assign tmr_run   = mem_req_q && !mem_ack;

  vpd_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tmr_start),
    .run    (tmr_run),
    .expired(tmr_exp)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    f_d         = f_q;
    data_d      = data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_ro_d    = 1'b0;
    err_to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_acc) begin
          data_d = cfg_wdata;
        end
        if (addr_acc) begin
          addr_d = new_addr;
          if (!cfg_wdata[VPD_F_BIT]) begin
            f_d        = 1'b0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = new_addr[ADDR_W-1:2];
            state_d    = RD_REQ;
          end else if (is_ro) begin
            f_d      = 1'b0;
            err_ro_d = 1'b1;
          end else begin
            // data_d already holds a same-cycle data write
            f_d         = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = new_addr[ADDR_W-1:2];
            mem_wdata_d = data_d;
            state_d     = WR_REQ;
          end
        end
      end
      RD_REQ, WR_REQ: begin
        if (mem_ack || tmr_exp) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          err_to_d  = !mem_ack || mem_err;
          if (state_q == RD_REQ) begin
            f_d    = 1'b1;
            data_d = (mem_ack && !mem_err) ? mem_rdata : VPD_ERR_DATA;
          end else begin
            f_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      f_q         <= 1'b0;
      data_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_ro_q    <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      f_q         <= f_d;
      data_q      <= data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_ro_q    <= err_ro_d;
      err_to_q    <= err_to_d;
    end
  end

  always_comb begin
    addr_ext               = '0;
    addr_ext[ADDR_W-1:0]   = addr_q;
  end

  assign vpd_addr_rd = {f_q, addr_ext};
  assign vpd_data_rd = data_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = !idle;
  assign err_ro      = err_ro_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_vpd_capability_ctrl.sv
// Directed and randomized checks of the VPD capability controller against a
// transaction-level model of the registers and backing store.
module tb_vpd_capability_ctrl;

  localparam int T = 16;

  logic        clk, rst_n;
  logic        cfg_addr_we, cfg_data_we;
  logic [31:0] cfg_wdata;
  logic [3:0]  cfg_be;
  logic [15:0] vpd_addr_rd;
  logic [31:0] vpd_data_rd;
  logic        mem_req, mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack, mem_err;
  logic [31:0] mem_rdata;
  logic        busy, err_ro, err_timeout;

  int checks   = 0;
  int failures = 0;

  vpd_capability_ctrl #(
    .ADDR_W        (15),
    .RO_LIMIT      ('h80),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_addr_we(cfg_addr_we),
    .cfg_data_we(cfg_data_we),
    .cfg_wdata  (cfg_wdata),
    .cfg_be     (cfg_be),
    .vpd_addr_rd(vpd_addr_rd),
    .vpd_data_rd(vpd_data_rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .busy       (busy),
    .err_ro     (err_ro),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic a_we, input logic d_we, input logic [31:0] w, input logic [3:0] be);
    cfg_addr_we = a_we;
    cfg_data_we = d_we;
    cfg_wdata   = w;
    cfg_be      = be;
    step();
    cfg_addr_we = 1'b0;
    cfg_data_we = 1'b0;
    cfg_wdata   = '0;
    cfg_be      = '0;
  endtask

  task automatic ack(input logic [31:0] rd, input logic err);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    mem_err   = err;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem_err   = 1'b0;
  endtask

  logic [31:0] store [int];
  logic [14:0] a, la;
  logic [31:0] m_data, rd, w;
  logic        m_f, e;
  int          n, kind, dly;

  initial begin
    rst_n = 1'b0;
    cfg_addr_we = 1'b0; cfg_data_we = 1'b0; cfg_wdata = '0; cfg_be = '0;
    mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_addr", 32'(vpd_addr_rd), 32'h0);
    chk("rst_data", vpd_data_rd, 32'h0);
    chk("rst_req_busy", {30'h0, mem_req, busy}, 32'h0);
    chk("rst_err", {30'h0, err_ro, err_timeout}, 32'h0);

    // Basic read, with an ignored partial data write first
    cfg(1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0111);
    chk("partial_data_ignored", vpd_data_rd, 32'h0);
    cfg(1'b1, 1'b0, 32'h0010_0000, 4'hF);
    chk("rd_req", {30'h0, mem_req, mem_we}, 32'h2);
    chk("rd_addr", 32'(mem_addr), 32'h4);
    chk("rd_busy", 32'(busy), 32'h1);
    repeat (2) step();
    ack(32'hCAFE_F00D, 1'b0);
    chk("rd_data", vpd_data_rd, 32'hCAFE_F00D);
    chk("rd_flag", 32'(vpd_addr_rd), 32'h8010);
    chk("rd_done", {30'h0, mem_req, busy}, 32'h0);

    // Basic write
    cfg(1'b0, 1'b1, 32'h1234_5678, 4'hF);
    cfg(1'b1, 1'b0, 32'h8100_0000, 4'hF);
    chk("wr_req", {30'h0, mem_req, mem_we}, 32'h3);
    chk("wr_addr", 32'(mem_addr), 32'h40);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_flag_set", 32'(vpd_addr_rd), 32'h8100);
    ack(32'h0, 1'b0);
    chk("wr_flag_clr", 32'(vpd_addr_rd), 32'h0100);
    chk("wr_done", 32'(mem_req), 32'h0);

    // Read-only rejection
    cfg(1'b1, 1'b0, 32'h8040_0000, 4'hF);
    chk("ro_noreq", {30'h0, mem_req, busy}, 32'h0);
    chk("ro_pulse", 32'(err_ro), 32'h1);
    chk("ro_flag", 32'(vpd_addr_rd), 32'h0040);
    step();
    chk("ro_pulse_end", 32'(err_ro), 32'h0);

    // Timeout on read
    cfg(1'b1, 1'b0, 32'h0020_0000, 4'hF);
    n = 0;
    while (mem_req && n < 4 * T) begin
      step();
      n++;
    end
    chk("to_cycles", 32'(n), 32'(T));
    chk("to_pulse", 32'(err_timeout), 32'h1);
    chk("to_data", vpd_data_rd, 32'hFFFF_FFFF);
    chk("to_flag", 32'(vpd_addr_rd), 32'h8020);
    step();
    chk("to_pulse_end", 32'(err_timeout), 32'h0);

    // mem_err behaves like a timeout
    cfg(1'b0, 1'b1, 32'h1111_2222, 4'hF);
    cfg(1'b1, 1'b0, 32'h0024_0000, 4'hF);
    ack(32'h5555_5555, 1'b1);
    chk("merr_pulse", 32'(err_timeout), 32'h1);
    chk("merr_data", vpd_data_rd, 32'hFFFF_FFFF);
    chk("merr_flag", 32'(vpd_addr_rd), 32'h8024);

    // Byte-enable and busy filtering
    cfg(1'b1, 1'b0, 32'h0030_0000, 4'b0011);
    chk("be_addr_ignored", {15'h0, mem_req, vpd_addr_rd}, 32'h8024);
    cfg(1'b1, 1'b0, 32'h0030_0000, 4'hF);
    cfg(1'b0, 1'b1, 32'hAAAA_AAAA, 4'hF);
    chk("busy_data_ignored", vpd_data_rd, 32'hFFFF_FFFF);
    chk("busy_rd_addr", 32'(mem_addr), 32'h0C);
    ack(32'h0BAD_CAFE, 1'b0);
    chk("busy_rd_data", vpd_data_rd, 32'h0BAD_CAFE);
    cfg(1'b1, 1'b0, 32'h8200_0000, 4'hF);
    cfg(1'b1, 1'b0, 32'h0300_0000, 4'hF);
    chk("busy_wr_addr", 32'(mem_addr), 32'h80);
    chk("busy_wr_we", {30'h0, mem_req, mem_we}, 32'h3);
    chk("busy_wr_flag", 32'(vpd_addr_rd), 32'h8200);
    chk("busy_wr_wdata", mem_wdata, 32'h0BAD_CAFE);
    ack(32'h0, 1'b0);
    chk("busy_wr_done", 32'(vpd_addr_rd), 32'h0200);

    // Same-cycle data and address write
    cfg(1'b1, 1'b1, 32'h8104_0000, 4'hF);
    chk("both_wdata", mem_wdata, 32'h8104_0000);
    chk("both_addr", 32'(mem_addr), 32'h41);
    chk("both_data", vpd_data_rd, 32'h8104_0000);
    ack(32'h0, 1'b0);

    // Reset during WR_REQ
    cfg(1'b0, 1'b1, 32'h7777_7777, 4'hF);
    cfg(1'b1, 1'b0, 32'h8400_0000, 4'hF);
    step();
    rst_n = 1'b0;
    #1;
    chk("rstmid_req_busy", {30'h0, mem_req, busy}, 32'h0);
    chk("rstmid_regs", {vpd_addr_rd, 15'h0, mem_we}, 32'h0);
    chk("rstmid_data", vpd_data_rd, 32'h0);
    chk("rstmid_mem", mem_wdata | 32'(mem_addr), 32'h0);
    chk("rstmid_err", {30'h0, err_ro, err_timeout}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    cfg(1'b1, 1'b0, 32'h0050_0000, 4'hF);
    chk("post_rst_req", {15'h0, mem_req, 3'h0, mem_addr}, 32'h1_0014);
    ack(32'h600D_600D, 1'b0);
    chk("post_rst_data", vpd_data_rd, 32'h600D_600D);
    chk("post_rst_flag", 32'(vpd_addr_rd), 32'h8050);

    // Randomized traffic against the transaction-level model
    m_data = 32'h600D_600D;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 'h1FF)) : 15'($urandom_range(0, 32767));
      la = {a[14:2], 2'b00};
      dly = $urandom_range(0, 3);
      e = ($urandom_range(0, 7) == 0);
      if (kind == 0) begin
        w = $urandom;
        cfg(1'b0, 1'b1, w, 4'hF);
        m_data = w;
        chk("rnd_data_wr", vpd_data_rd, m_data);
      end else if (kind == 1) begin
        cfg(1'b1, 1'b0, {1'b0, a, 16'h0}, 4'hF);
        chk("rnd_rd_req", {30'h0, mem_req, mem_we}, 32'h2);
        chk("rnd_rd_addr", 32'(mem_addr), 32'(la >> 2));
        if (!store.exists(int'(la >> 2))) store[int'(la >> 2)] = $urandom;
        rd = store[int'(la >> 2)];
        repeat (dly) step();
        ack(rd, e);
        m_data = e ? 32'hFFFF_FFFF : rd;
        m_f = 1'b1;
        chk("rnd_rd_data", vpd_data_rd, m_data);
        chk("rnd_rd_err", 32'(err_timeout), 32'(e));
        chk("rnd_rd_flag", 32'(vpd_addr_rd), {16'h0, m_f, la});
      end else begin
        cfg(1'b1, 1'b0, {1'b1, a, 16'h0}, 4'hF);
        m_f = 1'b0;
        if (int'(la) < 'h80) begin
          chk("rnd_ro_noreq", 32'(mem_req), 32'h0);
          chk("rnd_ro_pulse", 32'(err_ro), 32'h1);
        end else begin
          chk("rnd_wr_req", {30'h0, mem_req, mem_we}, 32'h3);
          chk("rnd_wr_addr", 32'(mem_addr), 32'(la >> 2));
          chk("rnd_wr_wdata", mem_wdata, m_data);
          repeat (dly) step();
          ack(32'h0, e);
          if (!e) store[int'(la >> 2)] = m_data;
          chk("rnd_wr_err", 32'(err_timeout), 32'(e));
        end
        chk("rnd_wr_flag", 32'(vpd_addr_rd), {16'h0, m_f, la});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vpd_capability_ctrl.md
Name: vpd_capability_ctrl

Overview:
PCIe VPD capability controller, parametrised successor to the single-cycle VPD data register.
- Implements the VPD Address register (15-bit address plus F flag) and the VPD Data register with standard F-flag completion semantics.
- Fronts a multi-cycle backing store through a req/ack handshake.
- Adds a configurable read-only region, a handshake timeout and error reporting.
- Sits between the config-space decode and the VPD storage (EEPROM/SRAM shim).

Parameters:
- ADDR_W, 15, VPD byte-address width; legal range 3..15. Storage dword address is ADDR_W-2 bits.
- RO_LIMIT, 'h80, byte address. Writes to addresses below this are rejected (read-only VPD fields).
- TIMEOUT_CYCLES, 1024, maximum cycles mem_req stays asserted before forced completion. Must be >= 2.
- TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_addr_we  in  1  config write strobe to the capability dword holding the VPD Address register (bits 31:16)
- cfg_data_we  in  1  config write strobe to the VPD Data register dword
- cfg_wdata  in  32  config write data
- cfg_be  in  4  config byte enables
- vpd_addr_rd  out  16  readback of {F, addr[14:0]}; address bits at or above ADDR_W read 0
- vpd_data_rd  out  32  readback of the VPD Data register
- mem_req  out  1  storage request, held until mem_ack or timeout
- mem_we  out  1  1 = write, 0 = read; stable while mem_req is high
- mem_addr  out  ADDR_W-2  storage dword address
- mem_wdata  out  32  storage write data
- mem_ack  in  1  single-cycle completion from storage
- mem_rdata  in  32  read data, valid with mem_ack
- mem_err  in  1  storage error, valid with mem_ack
- busy  out  1  operation in flight (state != IDLE)
- err_ro  out  1  one-cycle pulse: write to the read-only region rejected
- err_timeout  out  1  one-cycle pulse: timeout or mem_err completion

Behaviour:
- Reset: addr_reg=0, F=0, data_reg=0, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, err pulses=0, timeout counter=0.
- States: IDLE, RD_REQ, WR_REQ.
- Data write: accepted only when cfg_data_we=1, cfg_be=4'b1111 and state=IDLE; sets data_reg<=cfg_wdata. Partial byte enables or busy state -> ignored, no state change.
- Address write: accepted only when cfg_addr_we=1, cfg_be[3:2]=2'b11 and state=IDLE.
  - Latched address = cfg_wdata[16+ADDR_W-1:16] with bits [1:0] forced to 0.
  - F = cfg_wdata[31].
  - Otherwise the write is ignored.
- F=0 (read request): F<=0, mem_req<=1, mem_we<=0, mem_addr<=addr[ADDR_W-1:2], next state RD_REQ. mem_req rises the cycle after the accepted write.
- F=1 (write request):
  - addr < RO_LIMIT: no memory access, F<=0, err_ro pulses the next cycle, state stays IDLE.
  - Otherwise: F<=1, mem_req<=1, mem_we<=1, mem_wdata<=data_reg, next state WR_REQ.
- Same-cycle cfg_data_we and cfg_addr_we, both accepted: the data write takes effect first. A write request issued that cycle uses the new cfg_wdata as its write data.
- RD_REQ, cycle of mem_ack with mem_err=0: data_reg<=mem_rdata, F<=1, mem_req<=0, next state IDLE.
- WR_REQ, cycle of mem_ack with mem_err=0: F<=0, mem_req<=0, next state IDLE.
- mem_err=1 with mem_ack: treated as a timeout.
- Timeout counter: cleared on entering RD_REQ/WR_REQ, increments each cycle mem_req is high without mem_ack. Reaching TIMEOUT_CYCLES forces completion:
  - mem_req<=0, err_timeout pulses once.
  - Read: data_reg<='1 and F<=1.
  - Write: F<=0.
  - State returns to IDLE.
- mem_ack while in IDLE: ignored.
- mem_ack on the same cycle the counter expires: the ack wins, and the operation completes normally.
- Config writes are ignored throughout RD_REQ/WR_REQ; busy=1 in those states.
- Completion latency with a zero-wait store: acknowledge 1 cycle after mem_req rises. The F transition is visible on vpd_addr_rd the cycle after mem_ack.
- Reset mid-operation: everything returns to reset values immediately. mem_req drops asynchronously, and no error pulse is generated.

Decomposition:
- Package vpd_pkg:
  - vpd_state_e enum {IDLE, RD_REQ, WR_REQ}
  - VPD_F_BIT=31 (flag bit within the capability dword)
  - VPD_ERR_DATA=32'hFFFF_FFFF
  - VPD_ADDR_LSB=16
- One sub-module: vpd_timeout_timer. Parameter TIMEOUT_CYCLES; ports clk, rst_n, start, run, expired.
- Everything else stays in vpd_capability_ctrl.

Test Plan:
- Read: data write ignored; address write cfg_wdata=32'h0010_0000 with be=1111. Store acks 3 cycles later with rdata=32'hCAFE_F00D. Required: mem_addr=4, mem_we=0, vpd_data_rd=CAFE_F00D, vpd_addr_rd=16'h8010.
- Write: data write 32'h1234_5678, then address write 32'h8100_0000. Required: mem_we=1, mem_addr='h40, mem_wdata=1234_5678, F clears after ack, vpd_addr_rd=16'h0100.
- Read-only rejection: address write 32'h8040_0000 with RO_LIMIT='h80. Required: no mem_req, err_ro pulses one cycle, F=0.
- Timeout: read issued, mem_ack held low. Required: mem_req drops after TIMEOUT_CYCLES, err_timeout pulses, vpd_data_rd=FFFF_FFFF, F=1. Repeat with mem_err=1 on ack and require the same response.
- Busy and byte-enable filtering: address write with be=0011 ignored; data write during RD_REQ leaves data_reg unchanged; second address write during WR_REQ ignored; mem_addr stays stable throughout.
- Reset mid-WR_REQ: assert rst_n low during WR_REQ. Required: mem_req=0 and busy=0 immediately, all registers zero. A following read completes normally.
